// File: rtl/ifetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack, decode valid/ready,
// and the redirect input from later stages.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_opcode,
    output id_pc4,
    input  redirect,
    input  redirect_target
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_opcode,
    input  id_pc4,
    output redirect,
    output redirect_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and hands it to decode, honouring redirects.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  ifetch_unit_if.master    bus,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tgt;
  logic [31:0]      pc_inc;

  assign tgt    = {bus.redirect_target[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      addr_q  <= PC_RESET;
      instr_q <= '0;
      pc4_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.redirect) pc_d = tgt;
      end
      FETCH: begin
        if (bus.redirect) begin
          pc_d    = tgt;
          state_d = bus.imem_ack ? FETCH : DRAIN;
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          pc4_d   = pc_inc;
          pc_d    = pc_inc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (bus.id_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (bus.redirect) pc_d = tgt;
        if (bus.imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    // The abandoned address stays on the bus until memory acks it.
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  assign bus.imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = (state_q == HOLD);
  assign bus.id_instr  = instr_q;
  assign bus.id_opcode = instr_q[31:26];
  assign bus.id_pc4    = pc4_q;
  assign fetch_count   = cnt_q;

endmodule
